// File: rtl/rv_mem_arb.sv
// rv_mem_arb: two-port arbiter in front of the single-port unified memory.
// Port 0 is the core and port 1 is the host loader/DMA port. Each access goes
// IDLE -> ISSUE -> (WAIT) -> RESP. The winner gets a one-cycle ack, and read
// data comes back on the shared rdata_o.
// Optional feature macro: RV_ARB_FIXED_PRIO_EN. When it is defined, port 0
// always wins a tie. When it is undefined, ties are broken round-robin.
module rv_mem_arb #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req0_i,
  input  logic          req1_i,
  input  logic          we0_i,
  input  logic          we1_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] wdata0_i,
  input  logic [DW-1:0] wdata1_i,
  output logic          ack0_o,
  output logic          ack1_o,
  output logic [DW-1:0] rdata_o,
  output logic          busy_o,
  output logic          mem_en_o,
  output logic          mem_rw_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam int CW = 3;
  localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LAT - 1);
`ifdef RV_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e          state_q;
  logic            port_q;
  logic            last_gnt_q;
  logic [CW-1:0]   cnt_q;
  logic            ack0_q, ack1_q, busy_q, mem_en_q, mem_rw_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q, rdata_q;
  logic            win_d;

  // Pick the winner from the live requests. A lone request always wins.
  // On a tie, the port that was not granted last time wins, unless fixed
  // priority is enabled, in which case port 0 wins.
  always_comb begin
    win_d = 1'b0;
    if (req0_i && req1_i) win_d = FIXED_PRIO ? 1'b0 : ~last_gnt_q;
    else                  win_d = ~req0_i;
  end

  // The access FSM. All outputs are registered. mem_rw_q, mem_addr_q and
  // mem_wdata_q are loaded once, when the access is granted. They then serve
  // as the latched copy of the request for the rest of the access, and they
  // hold their values afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      port_q      <= 1'b0;
      last_gnt_q  <= 1'b1;
      cnt_q       <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      mem_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req0_i || req1_i) begin
            port_q      <= win_d;
            mem_rw_q    <= win_d ? we1_i    : we0_i;
            mem_addr_q  <= win_d ? addr1_i  : addr0_i;
            mem_wdata_q <= win_d ? wdata1_i : wdata0_i;
            mem_en_q    <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_rw_q) begin
            ack0_q  <= ~port_q;
            ack1_q  <= port_q;
            state_q <= S_RESP;
          end else begin
            cnt_q   <= LAT_LOAD;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            rdata_q <= mem_rdata_i;
            ack0_q  <= ~port_q;
            ack1_q  <= port_q;
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RESP: begin
          last_gnt_q <= port_q;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ack0_o      = ack0_q;
  assign ack1_o      = ack1_q;
  assign busy_o      = busy_q;
  assign mem_en_o    = mem_en_q;
  assign mem_rw_o    = mem_rw_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_rv_mem_arb.sv
// tb_rv_mem_arb: randomized and directed stimulus for rv_mem_arb. The bench
// includes a memory macro with a fixed read latency and a transaction-level
// reference model. The model predicts, cycle by cycle, the strobe, busy, ack
// and data outputs.
module tb_rv_mem_arb;
  localparam int LAT = 3;
`ifdef RV_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req0, req1, we0, we1, ack0, ack1, busy, mem_en, mem_rw;
  logic [31:0] addr0, addr1, wdata0, wdata1, rdata, mem_addr, mem_wdata, mem_rdata;

  rv_mem_arb #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .ack0_o(ack0), .ack1_o(ack1), .rdata_o(rdata), .busy_o(busy),
    .mem_en_o(mem_en), .mem_rw_o(mem_rw), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  function automatic logic [31:0] init_word(int i);
    return (i == 16) ? 32'h12345678 : (32'hA5000000 ^ (i * 32'h01030507));
  endfunction

  // Memory macro: 64 words. Read data appears LAT cycles after the strobe
  // cycle. In every other cycle the read pipe carries random garbage.
  logic [31:0] mem_arr [64];
  logic [31:0] rpipe   [8];
  bit          minit = 1'b0;
  always @(posedge clk) begin
    if (!minit) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= init_word(i);
      minit <= 1'b1;
    end else if (mem_en && mem_rw) begin
      mem_arr[mem_addr[7:2]] <= mem_wdata;
    end
    rpipe[0] <= (mem_en && !mem_rw) ? mem_arr[mem_addr[7:2]] : $urandom;
    for (int i = 1; i < 8; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[LAT-1];

  // Requester agents.
  bit          pend [2], grnt [2], drop [2], rq_we [2];
  logic [31:0] rq_addr [2], rq_wd [2];

  // Transaction-level reference model.
  bit          tr_v, tr_port, tr_we, last_gnt, e_rw;
  logic [31:0] tr_addr, tr_wd, tr_rd, e_addr, e_wd, e_rd;
  int          tr_en, tr_ack, m_free;
  logic [31:0] ref_mem [64];

  int errors = 0, checks = 0, cyc = 0, mode = 0;
  int ackq_port [$];
  int ackq_cyc  [$];
  int nack [2];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive();
    req0 = pend[0] && !drop[0];
    req1 = pend[1] && !drop[1];
    if (drop[0]) begin
      we0 = 1'($urandom_range(1)); addr0 = $urandom; wdata0 = $urandom;
    end else begin
      we0 = rq_we[0]; addr0 = rq_addr[0]; wdata0 = rq_wd[0];
    end
    if (drop[1]) begin
      we1 = 1'($urandom_range(1)); addr1 = $urandom; wdata1 = $urandom;
    end else begin
      we1 = rq_we[1]; addr1 = rq_addr[1]; wdata1 = rq_wd[1];
    end
  endtask

  task automatic post(int p, bit we, logic [31:0] a, logic [31:0] d);
    pend[p] = 1'b1; grnt[p] = 1'b0; drop[p] = 1'b0;
    rq_we[p] = we; rq_addr[p] = a; rq_wd[p] = d;
    drive();
  endtask

  // Run one clock cycle: grant in the model, then advance and check, then
  // compute the requester inputs for the new cycle.
  task automatic step();
    bit rp, en, b, a0, a1;
    int w;
    rp = rst;
    if (!rst && cyc >= m_free && (req0 || req1)) begin
      w = (req0 && req1) ? (FIXED ? 0 : (last_gnt ? 0 : 1)) : (req0 ? 0 : 1);
      tr_v = 1'b1; tr_port = w[0]; tr_we = rq_we[w];
      tr_addr = rq_addr[w]; tr_wd = rq_wd[w];
      tr_en = cyc + 1; tr_ack = cyc + 2 + (tr_we ? 0 : LAT); m_free = tr_ack + 1;
      last_gnt = w[0]; grnt[w] = 1'b1;
      if (tr_we) ref_mem[tr_addr[7:2]] = tr_wd;
      else       tr_rd = ref_mem[tr_addr[7:2]];
    end
    @(posedge clk); #1; cyc++;
    if (rp) begin
      tr_v = 1'b0; last_gnt = 1'b1; m_free = cyc;
      e_addr = '0; e_wd = '0; e_rw = 1'b0; e_rd = '0;
      pend[0] = 1'b0; pend[1] = 1'b0;
    end
    en = tr_v && cyc == tr_en;
    b  = tr_v && cyc >= tr_en && cyc <= tr_ack;
    a0 = tr_v && cyc == tr_ack && !tr_port;
    a1 = tr_v && cyc == tr_ack && tr_port;
    if (en) begin e_addr = tr_addr; e_wd = tr_wd; e_rw = tr_we; end
    if (tr_v && cyc == tr_ack && !tr_we) e_rd = tr_rd;
    chk("ack0", ack0, a0);
    chk("ack1", ack1, a1);
    chk("busy", busy, b);
    chk("mem_en", mem_en, en);
    chk("mem_rw", mem_rw, e_rw);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("rdata", rdata, e_rd);
    if (ack0) begin ackq_port.push_back(0); ackq_cyc.push_back(cyc); nack[0]++; end
    if (ack1) begin ackq_port.push_back(1); ackq_cyc.push_back(cyc); nack[1]++; end
    if (tr_v && cyc == tr_ack + 1) pend[tr_port] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (!pend[p]) begin
        if (mode == 2) post(p, 1'b0, $urandom, '0);
        else if (mode == 1 && $urandom_range(2) == 0)
          post(p, 1'($urandom_range(1)), $urandom, $urandom);
      end else if (mode == 1 && grnt[p] && !drop[p] && $urandom_range(3) == 0) begin
        drop[p] = 1'b1;
      end
    end
    drive();
  endtask

  task automatic drain();
    mode = 0;
    repeat (24) step();
  endtask

  initial begin
    int n0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; grnt[p] = 0; drop[p] = 0; rq_we[p] = 0; rq_addr[p] = 0; rq_wd[p] = 0;
      nack[p] = 0;
    end
    tr_v = 0; tr_port = 0; tr_we = 0; last_gnt = 1; e_rw = 0;
    tr_addr = 0; tr_wd = 0; tr_rd = 0; e_addr = 0; e_wd = 0; e_rd = 0;
    tr_en = 0; tr_ack = 0; m_free = 0;
    rst = 1'b1;
    drive();
    step(); step();
    rst = 1'b0;
    step();

    // Single core read of word 0x40.
    post(0, 1'b0, 32'h40, '0);
    drain();

    // Single host write.
    post(1, 1'b1, 32'h10, 32'hDEADBEEF);
    drain();

    // Both ports issue continuous reads: alternate, or port 0 only.
    ackq_port.delete(); ackq_cyc.delete();
    post(0, 1'b0, 32'h40, '0);
    post(1, 1'b0, 32'h10, '0);
    mode = 2;
    repeat (40) step();
    chk("contend_cnt", 32'(ackq_port.size() >= 4), 32'd1);
    if (ackq_port.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("contend_order", ackq_port[i], FIXED ? 0 : (i % 2));
        if (i > 0) chk("contend_gap", ackq_cyc[i] - ackq_cyc[i-1], LAT + 3);
      end
    end
    drain();

    // Port 0 drops its request and scrambles addr0 during WAIT.
    n0 = nack[0];
    post(0, 1'b0, 32'h80, '0);
    step(); step();
    drop[0] = 1'b1; drive();
    repeat (10) step();
    chk("drop_ack_once", nack[0] - n0, 1);
    drain();

    // Reset during WAIT: afterwards, a tie must go to port 0.
    post(0, 1'b1, 32'h20, 32'h5555AAAA);
    drain();
    post(1, 1'b0, 32'h44, '0);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ackq_port.delete(); ackq_cyc.delete();
    post(0, 1'b0, 32'h24, '0);
    post(1, 1'b0, 32'h28, '0);
    repeat (20) step();
    chk("rst_tie_cnt", 32'(ackq_port.size() >= 1), 32'd1);
    if (ackq_port.size() >= 1) chk("rst_tie_winner", ackq_port[0], 0);
    drain();

    // Random traffic with mid-transaction drops.
    mode = 1;
    repeat (3000) step();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
